// File: rtl/cci_s_host_model.sv
// rtl/cci_s_host_model.sv - system-side CCI-S loopback host model
// Serves AFU Tx read/write requests from a local line memory and injects CSR writes on C0 Rx.
module cci_s_host_model #(
  parameter int ADDR_W         = 10,
  parameter int RD_LAT         = 8,
  parameter int WR_LAT         = 4,
  parameter int RSP_DEPTH      = 32,
  parameter int ALMFULL_MARGIN = 8,
  parameter int INIT_DLY       = 16
) (
  input  logic         Clk_32UI,
  input  logic         Resetb,
  input  logic [60:0]  cf2ci_C0TxHdr,
  input  logic         cf2ci_C0TxRdValid,
  input  logic [60:0]  cf2ci_C1TxHdr,
  input  logic [511:0] cf2ci_C1TxData,
  input  logic         cf2ci_C1TxWrValid,
  input  logic         cf2ci_C1TxIntrValid,
  output logic         ci2cf_C0TxAlmFull,
  output logic         ci2cf_C1TxAlmFull,
  output logic [17:0]  rb2cf_C0RxHdr,
  output logic [511:0] rb2cf_C0RxData,
  output logic         rb2cf_C0RxRdValid,
  output logic         rb2cf_C0RxWrValid,
  output logic         rb2cf_C0RxCfgValid,
  output logic         rb2cf_C0RxUMsgValid,
  output logic         rb2cf_C0RxIntrValid,
  output logic         rb2cf_C1RxIntrValid,
  output logic [17:0]  rb2cf_C1RxHdr,
  output logic         rb2cf_C1RxWrValid,
  output logic         ci2cf_InitDn,
  input  logic         csr_wr_valid,
  input  logic [13:0]  csr_addr,
  input  logic [31:0]  csr_data,
  output logic [2:0]   err_sticky
);
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W  = $clog2(RSP_DEPTH + RD_LAT + 1);
  localparam int INIT_W = $clog2(INIT_DLY + 1);
  localparam logic [3:0] REQ_RD = 4'h4, REQ_WR = 4'h2, REQ_FENCE = 4'h5;
  localparam logic [3:0] RSP_RD = 4'h4, RSP_WR = 4'h1, RSP_CFG = 4'h0;

  logic              init_dn_q;
  logic [INIT_W-1:0] init_cnt_q;
  logic [3:0]        rd_type, wr_type;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              rd_ok, wr_line, wr_fence, bad_type, early_req;
  logic [511:0]      rd_data;
  logic              unused_ok;

  always_ff @(posedge Clk_32UI) begin
    if (!Resetb) begin
      init_cnt_q <= '0;
      init_dn_q  <= 1'b0;
    end else if (!init_dn_q) begin
      init_cnt_q <= init_cnt_q + INIT_W'(1);
      if (init_cnt_q == INIT_W'(INIT_DLY - 1)) init_dn_q <= 1'b1;
    end
  end

  assign rd_type   = cf2ci_C0TxHdr[55:52];
  assign wr_type   = cf2ci_C1TxHdr[55:52];
  assign rd_addr   = cf2ci_C0TxHdr[14 +: ADDR_W];
  assign wr_addr   = cf2ci_C1TxHdr[14 +: ADDR_W];
  assign rd_ok     = cf2ci_C0TxRdValid && init_dn_q && (rd_type == REQ_RD);
  assign wr_line   = cf2ci_C1TxWrValid && init_dn_q && (wr_type == REQ_WR);
  assign wr_fence  = cf2ci_C1TxWrValid && init_dn_q && (wr_type == REQ_FENCE);
  assign bad_type  = init_dn_q && ((cf2ci_C0TxRdValid && rd_type != REQ_RD) ||
                     (cf2ci_C1TxWrValid && wr_type != REQ_WR && wr_type != REQ_FENCE));
  assign early_req = !init_dn_q && (cf2ci_C0TxRdValid || cf2ci_C1TxWrValid);
  assign unused_ok = ^{cf2ci_C0TxHdr, cf2ci_C1TxHdr, cf2ci_C1TxIntrValid};

  // Backing store is deliberately not reset so data survives a port reset.
  logic [511:0] mem_q [2**ADDR_W];
  always_ff @(posedge Clk_32UI) begin
    if (wr_line) mem_q[wr_addr] <= cf2ci_C1TxData;
  end
  assign rd_data = (wr_line && wr_addr == rd_addr) ? cf2ci_C1TxData : mem_q[rd_addr];

  logic [RD_LAT-1:0] rdl_v_q;
  logic [13:0]       rdl_md_q   [RD_LAT];
  logic [511:0]      rdl_data_q [RD_LAT];

  always_ff @(posedge Clk_32UI) begin
    if (!Resetb) rdl_v_q <= '0;
    else         rdl_v_q <= (rdl_v_q << 1) | RD_LAT'(rd_ok);
  end

  always_ff @(posedge Clk_32UI) begin
    rdl_md_q[0]   <= cf2ci_C0TxHdr[13:0];
    rdl_data_q[0] <= rd_data;
    for (int i = 1; i < RD_LAT; i++) begin
      rdl_md_q[i]   <= rdl_md_q[i-1];
      rdl_data_q[i] <= rdl_data_q[i-1];
    end
  end

  logic [13:0]      fifo_md_q   [RSP_DEPTH];
  logic [511:0]     fifo_data_q [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             fifo_empty, fifo_full, push, pop, push_ok;
  logic             cfg_v_q;
  logic [13:0]      cfg_addr_q;
  logic [31:0]      cfg_data_q;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CNT_W'(RSP_DEPTH));
  assign push       = rdl_v_q[RD_LAT-1];
  // A pending CSR write owns C0 Rx this cycle, so the FIFO head waits.
  assign pop        = !fifo_empty && !cfg_v_q;
  assign push_ok    = push && (!fifo_full || pop);
  assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge Clk_32UI) begin
    if (!Resetb) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge Clk_32UI) begin
    if (push_ok) begin
      fifo_md_q[wr_ptr_q]   <= rdl_md_q[RD_LAT-1];
      fifo_data_q[wr_ptr_q] <= rdl_data_q[RD_LAT-1];
    end
  end

  always_ff @(posedge Clk_32UI) begin
    if (!Resetb) begin
      cfg_v_q    <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else begin
      cfg_v_q    <= csr_wr_valid;
      cfg_addr_q <= csr_addr;
      cfg_data_q <= csr_data;
    end
  end

  logic [OCC_W-1:0] occ;
  always_comb begin
    occ = OCC_W'(fifo_cnt_q);
    for (int i = 0; i < RD_LAT; i++) occ = occ + OCC_W'(rdl_v_q[i]);
  end

  assign ci2cf_C0TxAlmFull  = !init_dn_q || (occ >= OCC_W'(RSP_DEPTH - ALMFULL_MARGIN));
  assign ci2cf_C1TxAlmFull  = !init_dn_q;
  assign ci2cf_InitDn       = init_dn_q;
  assign rb2cf_C0RxRdValid  = pop;
  assign rb2cf_C0RxCfgValid = cfg_v_q;

  always_comb begin
    rb2cf_C0RxHdr  = '0;
    rb2cf_C0RxData = '0;
    if (cfg_v_q) begin
      rb2cf_C0RxHdr  = {RSP_CFG, cfg_addr_q};
      rb2cf_C0RxData = {480'b0, cfg_data_q};
    end else if (pop) begin
      rb2cf_C0RxHdr  = {RSP_RD, fifo_md_q[rd_ptr_q]};
      rb2cf_C0RxData = fifo_data_q[rd_ptr_q];
    end
  end

  logic [WR_LAT-1:0] wdl_v_q;
  logic [13:0]       wdl_md_q [WR_LAT];

  always_ff @(posedge Clk_32UI) begin
    if (!Resetb) wdl_v_q <= '0;
    else         wdl_v_q <= (wdl_v_q << 1) | WR_LAT'(wr_line || wr_fence);
  end

  always_ff @(posedge Clk_32UI) begin
    wdl_md_q[0] <= cf2ci_C1TxHdr[13:0];
    for (int i = 1; i < WR_LAT; i++) wdl_md_q[i] <= wdl_md_q[i-1];
  end

  assign rb2cf_C1RxWrValid = wdl_v_q[WR_LAT-1];
  assign rb2cf_C1RxHdr     = wdl_v_q[WR_LAT-1] ? {RSP_WR, wdl_md_q[WR_LAT-1]} : '0;

  assign rb2cf_C0RxWrValid   = 1'b0;
  assign rb2cf_C0RxUMsgValid = 1'b0;
  assign rb2cf_C0RxIntrValid = 1'b0;
  assign rb2cf_C1RxIntrValid = 1'b0;

  always_ff @(posedge Clk_32UI) begin
    if (!Resetb) err_sticky <= '0;
    else         err_sticky <= err_sticky | {early_req, bad_type, push && !push_ok};
  end
endmodule

// File: tb/tb_cci_s_host_model.sv
// tb/tb_cci_s_host_model.sv - scoreboard bench for cci_s_host_model
// Reference model: line memory array, expected-response queues, cycle-exact latencies.
module tb_cci_s_host_model;
  localparam int RD_LAT = 8, WR_LAT = 4, RSP_DEPTH = 32, ALMFULL_MARGIN = 8;
  localparam int INIT_DLY = 16, MEM_LINES = 1024;

  logic         Clk_32UI = 1'b0;
  logic         Resetb = 1'b0;
  logic [60:0]  cf2ci_C0TxHdr = '0;
  logic         cf2ci_C0TxRdValid = 1'b0;
  logic [60:0]  cf2ci_C1TxHdr = '0;
  logic [511:0] cf2ci_C1TxData = '0;
  logic         cf2ci_C1TxWrValid = 1'b0;
  logic         cf2ci_C1TxIntrValid = 1'b0;
  logic         csr_wr_valid = 1'b0;
  logic [13:0]  csr_addr = '0;
  logic [31:0]  csr_data = '0;
  logic         ci2cf_C0TxAlmFull, ci2cf_C1TxAlmFull, ci2cf_InitDn;
  logic [17:0]  rb2cf_C0RxHdr, rb2cf_C1RxHdr;
  logic [511:0] rb2cf_C0RxData;
  logic         rb2cf_C0RxRdValid, rb2cf_C0RxWrValid, rb2cf_C0RxCfgValid;
  logic         rb2cf_C0RxUMsgValid, rb2cf_C0RxIntrValid, rb2cf_C1RxIntrValid, rb2cf_C1RxWrValid;
  logic [2:0]   err_sticky;

  cci_s_host_model #(.ADDR_W(10), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .RSP_DEPTH(RSP_DEPTH),
                     .ALMFULL_MARGIN(ALMFULL_MARGIN), .INIT_DLY(INIT_DLY)) dut (
    .Clk_32UI(Clk_32UI), .Resetb(Resetb),
    .cf2ci_C0TxHdr(cf2ci_C0TxHdr), .cf2ci_C0TxRdValid(cf2ci_C0TxRdValid),
    .cf2ci_C1TxHdr(cf2ci_C1TxHdr), .cf2ci_C1TxData(cf2ci_C1TxData),
    .cf2ci_C1TxWrValid(cf2ci_C1TxWrValid), .cf2ci_C1TxIntrValid(cf2ci_C1TxIntrValid),
    .ci2cf_C0TxAlmFull(ci2cf_C0TxAlmFull), .ci2cf_C1TxAlmFull(ci2cf_C1TxAlmFull),
    .rb2cf_C0RxHdr(rb2cf_C0RxHdr), .rb2cf_C0RxData(rb2cf_C0RxData),
    .rb2cf_C0RxRdValid(rb2cf_C0RxRdValid), .rb2cf_C0RxWrValid(rb2cf_C0RxWrValid),
    .rb2cf_C0RxCfgValid(rb2cf_C0RxCfgValid), .rb2cf_C0RxUMsgValid(rb2cf_C0RxUMsgValid),
    .rb2cf_C0RxIntrValid(rb2cf_C0RxIntrValid), .rb2cf_C1RxIntrValid(rb2cf_C1RxIntrValid),
    .rb2cf_C1RxHdr(rb2cf_C1RxHdr), .rb2cf_C1RxWrValid(rb2cf_C1RxWrValid),
    .ci2cf_InitDn(ci2cf_InitDn), .csr_wr_valid(csr_wr_valid), .csr_addr(csr_addr),
    .csr_data(csr_data), .err_sticky(err_sticky)
  );

  always #5 Clk_32UI = ~Clk_32UI;

  int cyc = 0;
  always @(posedge Clk_32UI) cyc <= cyc + 1;

  typedef struct {
    logic [17:0]  hdr;
    logic [511:0] data;
    int           cyc;
  } exp_t;

  exp_t         rd_q[$], wr_q[$], cfg_q[$];
  logic [511:0] mem_m [MEM_LINES];
  logic [2:0]   exp_err = '0;
  int           n_checks = 0, n_fail = 0;
  int           rel_cyc = 0, rd_lat_exp = -1, drop_limit = -1, batch_cnt = 0;
  bit           mon_en = 1'b0;

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: response with nothing expected (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [60:0] mk_hdr(logic [3:0] ty, logic [31:0] addr, logic [13:0] md);
    logic [60:0] h;
    h = '0;
    h[55:52] = ty;
    h[45:14] = addr;
    h[13:0]  = md;
    return h;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  always @(negedge Clk_32UI) begin
    exp_t e;
    if (mon_en) begin
      if (rb2cf_C0RxRdValid === 1'b1 && rb2cf_C0RxCfgValid === 1'b1) unexpected("c0_overlap");
      if (rb2cf_C0RxCfgValid === 1'b1) begin
        if (cfg_q.size() == 0) unexpected("cfg");
        else begin
          e = cfg_q.pop_front();
          chk("cfg_hdr", rb2cf_C0RxHdr, e.hdr);
          chk("cfg_data", rb2cf_C0RxData, e.data);
          chk("cfg_cycle", cyc, e.cyc);
        end
      end
      if (rb2cf_C0RxRdValid === 1'b1) begin
        if (rd_q.size() == 0) unexpected("rd");
        else begin
          e = rd_q.pop_front();
          chk("rd_hdr", rb2cf_C0RxHdr, e.hdr);
          chk("rd_data", rb2cf_C0RxData, e.data);
          if (e.cyc >= 0) chk("rd_cycle", cyc, e.cyc);
        end
      end
      if (rb2cf_C1RxWrValid === 1'b1) begin
        if (wr_q.size() == 0) unexpected("wr");
        else begin
          e = wr_q.pop_front();
          chk("wr_hdr", rb2cf_C1RxHdr, e.hdr);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      chk("tied_zero", {rb2cf_C0RxWrValid, rb2cf_C0RxUMsgValid, rb2cf_C0RxIntrValid, rb2cf_C1RxIntrValid}, 0);
    end
  end

  task automatic clr();
    cf2ci_C0TxRdValid = 1'b0;
    cf2ci_C0TxHdr     = '0;
    cf2ci_C1TxWrValid = 1'b0;
    cf2ci_C1TxHdr     = '0;
    cf2ci_C1TxData    = '0;
    csr_wr_valid      = 1'b0;
    csr_addr          = '0;
    csr_data          = '0;
  endtask

  // Apply the presented inputs to the reference model, then advance one cycle.
  task automatic step();
    int   t, idx;
    bit   init_ok;
    exp_t e;
    t = cyc;
    init_ok = (cyc - rel_cyc) >= INIT_DLY;
    if (csr_wr_valid) begin
      e.hdr = {4'h0, csr_addr};
      e.data = {480'b0, csr_data};
      e.cyc = t + 1;
      cfg_q.push_back(e);
    end
    if (cf2ci_C1TxWrValid) begin
      if (!init_ok) exp_err[2] = 1'b1;
      else if (cf2ci_C1TxHdr[55:52] == 4'h2 || cf2ci_C1TxHdr[55:52] == 4'h5) begin
        idx = int'(cf2ci_C1TxHdr[45:14] % MEM_LINES);
        if (cf2ci_C1TxHdr[55:52] == 4'h2) mem_m[idx] = cf2ci_C1TxData;
        e.hdr = {4'h1, cf2ci_C1TxHdr[13:0]};
        e.data = '0;
        e.cyc = t + WR_LAT;
        wr_q.push_back(e);
      end else exp_err[1] = 1'b1;
    end
    if (cf2ci_C0TxRdValid) begin
      if (!init_ok) exp_err[2] = 1'b1;
      else if (cf2ci_C0TxHdr[55:52] == 4'h4) begin
        idx = int'(cf2ci_C0TxHdr[45:14] % MEM_LINES);
        if (drop_limit < 0 || batch_cnt < drop_limit) begin
          e.hdr = {4'h4, cf2ci_C0TxHdr[13:0]};
          e.data = mem_m[idx];
          e.cyc = (rd_lat_exp > 0) ? t + rd_lat_exp : -1;
          rd_q.push_back(e);
        end else exp_err[0] = 1'b1;
        batch_cnt++;
      end else exp_err[1] = 1'b1;
    end
    @(posedge Clk_32UI);
    #1;
    clr();
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while ((rd_q.size() + wr_q.size() + cfg_q.size()) != 0 && n < maxc) begin
      step();
      n++;
    end
    n_checks++;
    if ((rd_q.size() + wr_q.size() + cfg_q.size()) != 0) begin
      n_fail++;
      $display("FAIL drain: %0d rd %0d wr %0d cfg still outstanding after %0d cycles", rd_q.size(), wr_q.size(), cfg_q.size(), n);
    end
  endtask

  task automatic do_reset(int ncyc);
    clr();
    Resetb = 1'b0;
    repeat (ncyc) @(posedge Clk_32UI);
    #1;
    Resetb = 1'b1;
    rel_cyc = cyc;
    rd_q.delete();
    wr_q.delete();
    cfg_q.delete();
    exp_err = '0;
  endtask

  task automatic check_err(string nm);
    @(negedge Clk_32UI);
    chk(nm, err_sticky, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    mon_en = 1'b1;

    // Reset state and InitDn timing
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk_32UI);
      if (k == 0) begin
        chk("rst_valids", {rb2cf_C0RxRdValid, rb2cf_C0RxCfgValid, rb2cf_C1RxWrValid}, 0);
        chk("rst_c0_hdr", rb2cf_C0RxHdr, 0);
        chk("rst_c0_data", rb2cf_C0RxData, 0);
        chk("rst_c1_hdr", rb2cf_C1RxHdr, 0);
        chk("rst_err", err_sticky, 0);
      end
      chk("init_dn", ci2cf_InitDn, (k >= INIT_DLY));
      chk("c0_almfull_init", ci2cf_C0TxAlmFull, (k < INIT_DLY));
      chk("c1_almfull_init", ci2cf_C1TxAlmFull, (k < INIT_DLY));
      step();
    end

    // Write then wrapped read, plus a fence
    cf2ci_C1TxWrValid = 1'b1;
    cf2ci_C1TxHdr = mk_hdr(4'h2, 32'h5, 14'h12);
    cf2ci_C1TxData = {64{8'hA5}};
    step();
    cf2ci_C1TxWrValid = 1'b1;
    cf2ci_C1TxHdr = mk_hdr(4'h5, 32'h0, 14'h3F);
    step();
    cf2ci_C0TxRdValid = 1'b1;
    cf2ci_C0TxHdr = mk_hdr(4'h4, 32'h405, 14'h33);
    rd_lat_exp = RD_LAT + 1;
    step();
    rd_lat_exp = -1;
    drain(40);

    // Same-cycle write/read bypass
    cf2ci_C1TxWrValid = 1'b1;
    cf2ci_C1TxHdr = mk_hdr(4'h2, 32'h7, 14'h01);
    cf2ci_C1TxData = rand512();
    step();
    cf2ci_C1TxWrValid = 1'b1;
    cf2ci_C1TxHdr = mk_hdr(4'h2, 32'h7, 14'h02);
    cf2ci_C1TxData = 512'h1;
    cf2ci_C0TxRdValid = 1'b1;
    cf2ci_C0TxHdr = mk_hdr(4'h4, 32'h7, 14'h03);
    rd_lat_exp = RD_LAT + 1;
    step();
    rd_lat_exp = -1;
    drain(40);

    // CSR injection preempts a due read response
    cf2ci_C0TxRdValid = 1'b1;
    cf2ci_C0TxHdr = mk_hdr(4'h4, 32'h5, 14'h044);
    rd_lat_exp = RD_LAT + 2;
    step();
    rd_lat_exp = -1;
    repeat (RD_LAT - 1) step();
    csr_wr_valid = 1'b1;
    csr_addr = 14'h280;
    csr_data = 32'hDEADBEEF;
    step();
    drain(40);

    // Prefill, then randomized traffic
    for (int a = 0; a < 16; a++) begin
      cf2ci_C1TxWrValid = 1'b1;
      cf2ci_C1TxHdr = mk_hdr(4'h2, a, 14'(a));
      cf2ci_C1TxData = rand512();
      step();
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 40) begin
        cf2ci_C0TxRdValid = 1'b1;
        cf2ci_C0TxHdr = mk_hdr(4'h4, ($urandom_range(0, 3) << 10) | $urandom_range(0, 15), 14'($urandom()));
      end
      if ($urandom_range(0, 99) < 40) begin
        cf2ci_C1TxWrValid = 1'b1;
        cf2ci_C1TxHdr = mk_hdr(($urandom_range(0, 3) == 0) ? 4'h5 : 4'h2, ($urandom_range(0, 3) << 10) | $urandom_range(0, 15), 14'($urandom()));
        cf2ci_C1TxData = rand512();
      end
      if ($urandom_range(0, 99) < 25) begin
        csr_wr_valid = 1'b1;
        csr_addr = 14'($urandom());
        csr_data = $urandom();
      end
      step();
    end
    drain(200);
    check_err("err_after_random");

    // Back-pressure: 32 reads with C0 Rx held by CSR writes
    for (int i = 0; i < 32; i++) begin
      csr_wr_valid = 1'b1;
      csr_addr = 14'(i);
      csr_data = $urandom();
      cf2ci_C0TxRdValid = 1'b1;
      cf2ci_C0TxHdr = mk_hdr(4'h4, i % 16, 14'(14'h100 + i));
      step();
      @(negedge Clk_32UI);
      chk("c0_almfull_fill", ci2cf_C0TxAlmFull, (i + 1 >= RSP_DEPTH - ALMFULL_MARGIN));
    end
    for (int i = 0; i < 12; i++) begin
      csr_wr_valid = 1'b1;
      csr_data = $urandom();
      step();
    end
    @(negedge Clk_32UI);
    chk("c0_almfull_held", ci2cf_C0TxAlmFull, 1);
    drain(200);
    check_err("err_after_32");
    chk("c0_almfull_drained", ci2cf_C0TxAlmFull, 0);

    // Overflow: 40 reads with C0 Rx held
    drop_limit = RSP_DEPTH;
    batch_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      csr_wr_valid = 1'b1;
      csr_data = $urandom();
      cf2ci_C0TxRdValid = 1'b1;
      cf2ci_C0TxHdr = mk_hdr(4'h4, i % 16, 14'(14'h200 + i));
      step();
    end
    for (int i = 0; i < 12; i++) begin
      csr_wr_valid = 1'b1;
      csr_data = $urandom();
      step();
    end
    check_err("err_overflow");
    drain(200);
    drop_limit = -1;
    repeat (5) step();

    // Unsupported request type on both channels
    cf2ci_C0TxRdValid = 1'b1;
    cf2ci_C0TxHdr = mk_hdr(4'h9, 32'h1, 14'h55);
    cf2ci_C1TxWrValid = 1'b1;
    cf2ci_C1TxHdr = mk_hdr(4'h9, 32'h1, 14'h56);
    cf2ci_C1TxData = rand512();
    step();
    repeat (15) step();
    check_err("err_bad_type");

    // Reset mid-stream discards in-flight work; early request flagged
    for (int i = 0; i < 3; i++) begin
      cf2ci_C0TxRdValid = 1'b1;
      cf2ci_C0TxHdr = mk_hdr(4'h4, i, 14'(14'h300 + i));
      cf2ci_C1TxWrValid = 1'b1;
      cf2ci_C1TxHdr = mk_hdr(4'h2, 32'h8 + i, 14'(14'h310 + i));
      cf2ci_C1TxData = rand512();
      step();
    end
    do_reset(1);
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk_32UI);
      if (k == 0) chk("err_after_reset", err_sticky, 0);
      chk("init_dn_rerun", ci2cf_InitDn, (k >= INIT_DLY));
      if (k == 2) begin
        cf2ci_C0TxRdValid = 1'b1;
        cf2ci_C0TxHdr = mk_hdr(4'h4, 32'h5, 14'h77);
      end
      step();
    end
    repeat (10) step();
    check_err("err_early_req");

    // Memory survives reset
    cf2ci_C0TxRdValid = 1'b1;
    cf2ci_C0TxHdr = mk_hdr(4'h4, 32'h9, 14'h99);
    rd_lat_exp = RD_LAT + 1;
    step();
    rd_lat_exp = -1;
    drain(40);
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
